// File: rtl/io_device_bridge.sv
// io_device_bridge: buffers producer words into the CPU in-port register and
// captures CPU out-port writes into a FIFO drained over valid/ready.
module io_device_bridge #(
  parameter int WIDTH     = 32,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         src_valid,
  input  logic [WIDTH-1:0]             src_data,
  output logic                         src_ready,
  output logic [WIDTH-1:0]             device_data,
  output logic                         in_strobe,
  input  logic                         cpu_in_taken,
  output logic                         in_pending,
  input  logic                         out_write,
  input  logic [WIDTH-1:0]             out_data,
  output logic                         snk_valid,
  output logic [WIDTH-1:0]             snk_data,
  input  logic                         snk_ready,
  output logic                         out_overflow,
  input  logic                         ovf_clear,
  output logic [$clog2(IN_DEPTH):0]    in_count,
  output logic [$clog2(OUT_DEPTH):0]   out_count
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int OCW = OAW + 1;
  typedef enum logic [1:0] {I_IDLE, I_LOAD, I_HELD} state_t;
  state_t state;
  logic [WIDTH-1:0] in_mem [IN_DEPTH];
  logic [WIDTH-1:0] out_mem [OUT_DEPTH];
  logic [IAW:0] in_wr, in_rd, in_next;
  logic [OAW:0] out_wr, out_rd;
  logic in_push, in_pop, out_push, out_pop, out_full, out_drop;
  assign in_count  = in_wr - in_rd;
  assign out_count = out_wr - out_rd;
  assign snk_valid = out_count != '0;
  assign snk_data  = snk_valid ? out_mem[out_rd[OAW-1:0]] : '0;
  always_comb begin
    in_push  = src_valid && src_ready;
    in_pop   = state == I_IDLE && in_count != '0;
    in_next  = in_count + ICW'(in_push) - ICW'(in_pop);
    out_pop  = snk_valid && snk_ready;
    out_full = out_count == OCW'(OUT_DEPTH);
    out_push = out_write && (!out_full || out_pop);
    out_drop = out_write && out_full && !out_pop;
  end
  always_ff @(posedge clock) begin
    if (in_push) in_mem[in_wr[IAW-1:0]] <= src_data;
    if (out_push) out_mem[out_wr[OAW-1:0]] <= out_data;
  end
  // src_ready is registered on next-cycle fullness, so it reads 0 throughout reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_wr        <= '0;
      in_rd        <= '0;
      src_ready    <= 1'b0;
      state        <= I_IDLE;
      device_data  <= '0;
      in_strobe    <= 1'b0;
      in_pending   <= 1'b0;
      out_wr       <= '0;
      out_rd       <= '0;
      out_overflow <= 1'b0;
    end else begin
      in_wr        <= in_wr + ICW'(in_push);
      in_rd        <= in_rd + ICW'(in_pop);
      src_ready    <= in_next != ICW'(IN_DEPTH);
      in_strobe    <= in_pop;
      case (state)
        I_IDLE: if (in_pop) begin
          device_data <= in_mem[in_rd[IAW-1:0]];
          state       <= I_LOAD;
        end
        I_LOAD: begin
          in_pending <= 1'b1;
          state      <= I_HELD;
        end
        I_HELD: if (cpu_in_taken) begin
          in_pending <= 1'b0;
          state      <= I_IDLE;
        end
        default: state <= I_IDLE;
      endcase
      out_wr       <= out_wr + OCW'(out_push);
      out_rd       <= out_rd + OCW'(out_pop);
      out_overflow <= out_drop || (out_overflow && !ovf_clear);
    end
  end
endmodule

// File: tb/tb_io_device_bridge.sv
// tb_io_device_bridge: directed and randomized checks of io_device_bridge against a queue-based model.
module tb_io_device_bridge;
  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic src_valid = 1'b0, cpu_in_taken = 1'b0, out_write = 1'b0, snk_ready = 1'b0, ovf_clear = 1'b0;
  logic [31:0] src_data = '0, out_data = '0;
  logic src_ready, in_strobe, in_pending, snk_valid, out_overflow;
  logic [31:0] device_data, snk_data;
  logic [2:0] in_count, out_count;
  int checks = 0, errors = 0;
  logic [31:0] m_inq[$], m_outq[$];
  logic [31:0] m_dev;
  bit m_strobe, m_pending, m_ovf, m_srdy;

  io_device_bridge #(.WIDTH(32), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .device_data(device_data), .in_strobe(in_strobe),
    .cpu_in_taken(cpu_in_taken), .in_pending(in_pending), .out_write(out_write),
    .out_data(out_data), .snk_valid(snk_valid), .snk_data(snk_data),
    .snk_ready(snk_ready), .out_overflow(out_overflow), .ovf_clear(ovf_clear),
    .in_count(in_count), .out_count(out_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inq.delete();
    m_outq.delete();
    m_dev = '0;
    m_strobe = 0;
    m_pending = 0;
    m_ovf = 0;
    m_srdy = 0;
  endtask

  task automatic check_all();
    chk("src_ready", 32'(src_ready), 32'(m_srdy));
    chk("device_data", device_data, m_dev);
    chk("in_strobe", 32'(in_strobe), 32'(m_strobe));
    chk("in_pending", 32'(in_pending), 32'(m_pending));
    chk("in_count", 32'(in_count), 32'(m_inq.size()));
    chk("out_count", 32'(out_count), 32'(m_outq.size()));
    chk("snk_valid", 32'(snk_valid), 32'(m_outq.size() != 0));
    chk("snk_data", snk_data, m_outq.size() != 0 ? m_outq[0] : 32'h0);
    chk("out_overflow", 32'(out_overflow), 32'(m_ovf));
  endtask

  // One rising edge; the model advances by the behavioural rules, then all outputs are compared.
  task automatic tick();
    bit acc, ld, popo, drop, npend;
    acc   = src_valid && m_srdy;
    ld    = !m_strobe && !m_pending && m_inq.size() != 0;
    popo  = m_outq.size() != 0 && snk_ready;
    drop  = out_write && m_outq.size() == OUT_DEPTH && !popo;
    npend = m_strobe ? 1'b1 : (m_pending && cpu_in_taken) ? 1'b0 : m_pending;
    @(posedge clock);
    #1;
    if (ld) m_dev = m_inq.pop_front();
    m_strobe = ld;
    m_pending = npend;
    if (acc) m_inq.push_back(src_data);
    m_srdy = m_inq.size() < IN_DEPTH;
    if (popo) void'(m_outq.pop_front());
    if (out_write && !drop) m_outq.push_back(out_data);
    m_ovf = drop || (m_ovf && !ovf_clear);
    check_all();
  endtask

  initial begin
    logic [31:0] w2[8];
    logic [31:0] last;
    logic [31:0] in_words[10], out_words[10];
    logic [31:0] rx_in[$], rx_out[$];
    int idx, si, so, cyc;
    bit acc;
    model_reset();
    #3;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("ready_after_reset", 32'(src_ready), 32'd1);

    // single word load and CPU take
    src_valid = 1; src_data = 32'h36;
    tick();
    src_valid = 0;
    tick();
    chk("t1_strobe", 32'(in_strobe), 32'd1);
    chk("t1_data", device_data, 32'h36);
    tick();
    chk("t1_strobe_drop", 32'(in_strobe), 32'd0);
    chk("t1_pending", 32'(in_pending), 32'd1);
    cpu_in_taken = 1;
    tick();
    cpu_in_taken = 0;
    chk("t1_taken", 32'(in_pending), 32'd0);

    // input backpressure
    for (int i = 0; i < 8; i++) w2[i] = 32'h100 + i;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      src_valid = idx < 6; src_data = w2[idx];
      acc = src_valid && src_ready;
      tick();
      if (acc) idx++;
    end
    chk("t2_count", 32'(in_count), 32'd4);
    chk("t2_ready", 32'(src_ready), 32'd0);
    chk("t2_word0", device_data, 32'h100);
    chk("t2_accepted5", 32'(idx), 32'd5);
    for (int k = 0; k < 3; k++) begin
      src_valid = idx < 6; src_data = w2[idx];
      cpu_in_taken = k == 0;
      acc = src_valid && src_ready;
      tick();
      if (acc) idx++;
    end
    chk("t2_word1", device_data, 32'h101);
    chk("t2_accepted6", 32'(idx), 32'd6);
    src_valid = 0;
    for (int k = 0; k < 40; k++) begin
      cpu_in_taken = m_pending;
      tick();
    end
    cpu_in_taken = 0;
    chk("t2_drained", 32'(in_count), 32'd0);
    chk("t2_last", device_data, 32'h105);

    // output overflow and sticky flag
    snk_ready = 0;
    for (int i = 0; i < 5; i++) begin
      out_write = 1; out_data = 32'hA1 + i;
      tick();
    end
    chk("t3_count", 32'(out_count), 32'd4);
    chk("t3_ovf", 32'(out_overflow), 32'd1);
    out_data = 32'hA6; ovf_clear = 1;
    tick();
    chk("t3_ovf_kept", 32'(out_overflow), 32'd1);
    out_write = 0; ovf_clear = 0; snk_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", snk_data, 32'hA1 + i);
      tick();
    end
    snk_ready = 0; ovf_clear = 1;
    tick();
    ovf_clear = 0;
    chk("t3_ovf_clear", 32'(out_overflow), 32'd0);

    // pop and push on a full output FIFO
    for (int i = 0; i < 4; i++) begin
      out_write = 1; out_data = 32'hC0 + i;
      tick();
    end
    out_data = 32'hB0; snk_ready = 1;
    tick();
    out_write = 0;
    chk("t4_no_ovf", 32'(out_overflow), 32'd0);
    chk("t4_count", 32'(out_count), 32'd4);
    last = '0;
    for (int i = 0; i < 4; i++) begin
      last = snk_data;
      tick();
    end
    snk_ready = 0;
    chk("t4_last", last, 32'hB0);

    // asynchronous reset mid-transfer
    for (int i = 0; i < 4; i++) begin
      src_valid = 1; src_data = 32'h200 + i;
      out_write = i < 3; out_data = 32'h300 + i;
      tick();
    end
    src_valid = 0; out_write = 0;
    chk("t5_in_count", 32'(in_count), 32'd3);
    chk("t5_out_count", 32'(out_count), 32'd3);
    chk("t5_held", 32'(in_pending), 32'd1);
    #2 reset = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1;
    tick();

    // randomized streaming in both directions
    for (int i = 0; i < 10; i++) begin
      in_words[i] = $urandom;
      out_words[i] = $urandom;
    end
    si = 0; so = 0; cyc = 0;
    while ((rx_in.size() < 10 || rx_out.size() < 10) && cyc < 600) begin
      src_valid = si < 10 && $urandom_range(0, 1) == 1;
      src_data = in_words[si < 10 ? si : 9];
      acc = src_valid && src_ready;
      out_write = so < 10 && m_outq.size() < OUT_DEPTH && $urandom_range(0, 1) == 1;
      out_data = out_words[so < 10 ? so : 9];
      if (out_write) so++;
      snk_ready = $urandom_range(0, 2) != 0;
      cpu_in_taken = $urandom_range(0, 1) == 1;
      if (snk_valid && snk_ready) rx_out.push_back(snk_data);
      tick();
      if (acc) si++;
      if (in_strobe) rx_in.push_back(device_data);
      cyc++;
    end
    src_valid = 0; out_write = 0; snk_ready = 0; cpu_in_taken = 0;
    chk("t6_in_received", 32'(rx_in.size()), 32'd10);
    chk("t6_out_received", 32'(rx_out.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk("t6_in_order", i < rx_in.size() ? rx_in[i] : 32'hDEAD, in_words[i]);
      chk("t6_out_order", i < rx_out.size() ? rx_out[i] : 32'hDEAD, out_words[i]);
    end
    chk("t6_no_ovf", 32'(out_overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
